cpu_control_sequencer: RTL

//  Multi-cycle control FSM for the 16-bit CPU. Sequences FETCH/EXEC/MEM/WB around the combinational

---
 rtl/cpu_seq_pkg.sv | 35 +++
 rtl/cpu_seq_class_decode.sv | 36 +++
 rtl/cpu_control_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU control sequencer: FSM states, opcode classes,
// the HALT opcode pattern, PC-select codes and the decoded-class bundle.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6,
    ST_STEPW = 3'd7
  } state_e;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_LOAD   = 2'b01;
  localparam logic [1:0] CLS_STORE  = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  localparam logic [4:0] HALT_PAT = 5'b11111;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;

  typedef struct packed {
    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_halt;
  } iclass_t;

endpackage

// File: rtl/cpu_seq_class_decode.sv
// Combinational opcode-class decode of the instruction register.
// The HALT pattern lives inside class 11 and wins over BRANCH.
module cpu_seq_class_decode
  import cpu_seq_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] IR,
  output iclass_t       cls
);

  logic [1:0] opc_s;
  logic       halt_s;
  logic       unused_ir_s;

  assign opc_s       = IR[IW-1:IW-2];
  assign halt_s      = (IR[IW-1:IW-5] == HALT_PAT);
  assign unused_ir_s = ^IR[IW-6:0];

  // One-hot class flags from the opcode field
  always_comb begin
    cls = '0;
    if (halt_s) begin
      cls.is_halt = 1'b1;
    end else begin
      case (opc_s)
        CLS_ALU:    cls.is_alu    = 1'b1;
        CLS_LOAD:   cls.is_load   = 1'b1;
        CLS_STORE:  cls.is_store  = 1'b1;
        CLS_BRANCH: cls.is_branch = 1'b1;
        default:    cls           = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB control FSM for the 16-bit CPU.
// Define CPU_SEQ_STEP_EN to park in STEPW after every retire until a rising edge on step.
module cpu_control_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int IW     = 16,
  parameter int MEM_TO = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] IR,
  input  logic          mem_ready,
  input  logic          branch_cond,
  input  logic          step,
  output logic [2:0]    State,
  output logic [1:0]    PS,
  output logic          IR_L,
  output logic          WR,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          instr_done,
  output logic          halted,
  output logic          mem_fault
);

  localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

`ifdef CPU_SEQ_STEP_EN
  localparam state_e RETIRE_ST = ST_STEPW;
`else
  localparam state_e RETIRE_ST = ST_FETCH;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_is_load_q, mem_is_load_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          wr_q, wr_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;

  logic          wait_s;
  logic          timeout_s;
  logic          ir_l_s;
  logic [1:0]    ps_s;
  logic          done_s;
  iclass_t       cls_s;

  cpu_seq_class_decode #(.IW(IW)) u_class_decode (
    .IR  (IR),
    .cls (cls_s)
  );

`ifdef CPU_SEQ_STEP_EN
  logic step_q, step_d, step_rise_s;

  assign step_d      = step;
  assign step_rise_s = step & ~step_q;

  // Previous step level for edge detection, so a held step fires only once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end
`else
  logic unused_step_s;

  assign unused_step_s = step;
`endif

  assign wait_s    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign timeout_s = (MEM_TO != 0) && wait_s && (cnt_q == CW'(MEM_TO - 1));

  // State register, timeout counter and registered request/status strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RST;
      cnt_q         <= '0;
      mem_is_load_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      wr_q          <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_is_load_q <= mem_is_load_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      wr_q          <= wr_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state logic and handshake timeout counting
  always_comb begin
    state_d       = state_q;
    mem_is_load_d = mem_is_load_q;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (timeout_s) begin
          state_d = ST_FAULT;
        end else if (mem_ready) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (cls_s.is_halt) begin
          state_d = ST_HALT;
        end else if (cls_s.is_branch) begin
          state_d = RETIRE_ST;
        end else if (cls_s.is_load) begin
          state_d       = ST_MEM;
          mem_is_load_d = 1'b1;
        end else if (cls_s.is_store) begin
          state_d       = ST_MEM;
          mem_is_load_d = 1'b0;
        end else if (cls_s.is_alu) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (timeout_s) begin
          state_d = ST_FAULT;
        end else if (mem_ready) begin
          state_d = mem_is_load_q ? ST_WB : RETIRE_ST;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:    state_d = RETIRE_ST;
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      ST_STEPW: begin
`ifdef CPU_SEQ_STEP_EN
        if (step_rise_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_STEPW;
        end
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FAULT;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output logic: handshake-qualified strobes this cycle, request flops for the next state
  always_comb begin
    ir_l_s      = 1'b0;
    ps_s        = PS_HOLD;
    done_s      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    wr_d        = 1'b0;
    halted_d    = 1'b0;
    fault_d     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_l_s = 1'b1;
          ps_s   = PS_INC;
        end else begin
          ir_l_s = 1'b0;
        end
      end
      ST_EXEC: begin
        if (cls_s.is_halt) begin
          done_s = 1'b1;
        end else if (cls_s.is_branch) begin
          done_s = 1'b1;
          ps_s   = branch_cond ? PS_BR : PS_HOLD;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_MEM: done_s = mem_ready && !mem_is_load_q;
      ST_WB:  done_s = 1'b1;
      default: done_s = 1'b0;
    endcase

    // Requests are registered from the state being entered so they drop with the state
    case (state_d)
      ST_FETCH: mem_read_d = 1'b1;
      ST_MEM: begin
        mem_read_d  = mem_is_load_d;
        mem_write_d = !mem_is_load_d;
      end
      ST_WB:    wr_d     = 1'b1;
      ST_HALT:  halted_d = 1'b1;
      ST_FAULT: fault_d  = 1'b1;
      default:  wr_d     = 1'b0;
    endcase
  end

  assign State      = state_q;
  assign PS         = ps_s;
  assign IR_L       = ir_l_s;
  assign WR         = wr_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign instr_done = done_s;
  assign halted     = halted_q;
  assign mem_fault  = fault_q;

endmodule
